md5_update: RTL and testbench

Single-block MD5 compression engine. On a start request it runs the 64 MD5 steps on one 512-bit message block, seeded with the caller's chaining values A–D, one step per clock. It returns the final working registers a–d and toggles `complete`. The surrounding message/padding controller adds a–d to its own chaining values (A+a, B+b, …) and drives the next block.

---
 rtl/md5_update.sv | 197 +++++++++++++++++++
 tb/tb_md5_update.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_update.sv
// Single-block MD5 compression engine: 64 steps, one per clock, seeded with A-D.
// The message block port is named msg because "string" is a reserved word in SystemVerilog.
module md5_update (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] msg,
  input  logic         en,
  input  logic [8:0]   input_len,
  input  logic [31:0]  A,
  input  logic [31:0]  B,
  input  logic [31:0]  C,
  input  logic [31:0]  D,
  output logic [31:0]  a,
  output logic [31:0]  b,
  output logic [31:0]  c,
  output logic [31:0]  d,
  output logic         complete,
  output logic [7:0]   count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic          en_q;
  logic          start;
  logic [511:0]  blk;
  logic [31:0]   wa, wb, wc, wd;
  logic [5:0]    step;
  logic [1:0]    round;
  logic [31:0]   fn;
  logic [3:0]    g_idx;
  logic [4:0]    shamt;
  logic [31:0]   k_const;
  logic [31:0]   m_word;
  logic [31:0]   t_sum;
  logic [63:0]   rot_wide;
  logic [31:0]   new_b;
  logic          last_step;
  logic          unused_len;

  // The block length is informational only; the datapath never looks at it.
  assign unused_len = ^input_len;

  assign start     = en & ~en_q;
  assign step      = count[5:0];
  assign round     = step[5:4];
  assign last_step = (count == 8'd63);

  always_comb begin
    fn    = 32'd0;
    g_idx = 4'd0;
    case (round)
      2'd0: begin
        fn    = (wb & wc) | (~wb & wd);
        g_idx = step[3:0];
      end
      2'd1: begin
        fn    = (wb & wd) | (wc & ~wd);
        g_idx = step[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        fn    = wb ^ wc ^ wd;
        g_idx = step[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        fn    = wc ^ (wb | ~wd);
        g_idx = step[3:0] * 4'd7;
      end
    endcase
  end

  always_comb begin
    shamt = 5'd0;
    case ({round, step[1:0]})
      4'd0:  shamt = 5'd7;
      4'd1:  shamt = 5'd12;
      4'd2:  shamt = 5'd17;
      4'd3:  shamt = 5'd22;
      4'd4:  shamt = 5'd5;
      4'd5:  shamt = 5'd9;
      4'd6:  shamt = 5'd14;
      4'd7:  shamt = 5'd20;
      4'd8:  shamt = 5'd4;
      4'd9:  shamt = 5'd11;
      4'd10: shamt = 5'd16;
      4'd11: shamt = 5'd23;
      4'd12: shamt = 5'd6;
      4'd13: shamt = 5'd10;
      4'd14: shamt = 5'd15;
      default: shamt = 5'd21;
    endcase
  end

  // Sine-derived additive constants, one per step.
  always_comb begin
    k_const = 32'd0;
    case (step)
      6'd0:  k_const = 32'hd76aa478;  6'd1:  k_const = 32'he8c7b756;
      6'd2:  k_const = 32'h242070db;  6'd3:  k_const = 32'hc1bdceee;
      6'd4:  k_const = 32'hf57c0faf;  6'd5:  k_const = 32'h4787c62a;
      6'd6:  k_const = 32'ha8304613;  6'd7:  k_const = 32'hfd469501;
      6'd8:  k_const = 32'h698098d8;  6'd9:  k_const = 32'h8b44f7af;
      6'd10: k_const = 32'hffff5bb1;  6'd11: k_const = 32'h895cd7be;
      6'd12: k_const = 32'h6b901122;  6'd13: k_const = 32'hfd987193;
      6'd14: k_const = 32'ha679438e;  6'd15: k_const = 32'h49b40821;
      6'd16: k_const = 32'hf61e2562;  6'd17: k_const = 32'hc040b340;
      6'd18: k_const = 32'h265e5a51;  6'd19: k_const = 32'he9b6c7aa;
      6'd20: k_const = 32'hd62f105d;  6'd21: k_const = 32'h02441453;
      6'd22: k_const = 32'hd8a1e681;  6'd23: k_const = 32'he7d3fbc8;
      6'd24: k_const = 32'h21e1cde6;  6'd25: k_const = 32'hc33707d6;
      6'd26: k_const = 32'hf4d50d87;  6'd27: k_const = 32'h455a14ed;
      6'd28: k_const = 32'ha9e3e905;  6'd29: k_const = 32'hfcefa3f8;
      6'd30: k_const = 32'h676f02d9;  6'd31: k_const = 32'h8d2a4c8a;
      6'd32: k_const = 32'hfffa3942;  6'd33: k_const = 32'h8771f681;
      6'd34: k_const = 32'h6d9d6122;  6'd35: k_const = 32'hfde5380c;
      6'd36: k_const = 32'ha4beea44;  6'd37: k_const = 32'h4bdecfa9;
      6'd38: k_const = 32'hf6bb4b60;  6'd39: k_const = 32'hbebfbc70;
      6'd40: k_const = 32'h289b7ec6;  6'd41: k_const = 32'heaa127fa;
      6'd42: k_const = 32'hd4ef3085;  6'd43: k_const = 32'h04881d05;
      6'd44: k_const = 32'hd9d4d039;  6'd45: k_const = 32'he6db99e5;
      6'd46: k_const = 32'h1fa27cf8;  6'd47: k_const = 32'hc4ac5665;
      6'd48: k_const = 32'hf4292244;  6'd49: k_const = 32'h432aff97;
      6'd50: k_const = 32'hab9423a7;  6'd51: k_const = 32'hfc93a039;
      6'd52: k_const = 32'h655b59c3;  6'd53: k_const = 32'h8f0ccc92;
      6'd54: k_const = 32'hffeff47d;  6'd55: k_const = 32'h85845dd1;
      6'd56: k_const = 32'h6fa87e4f;  6'd57: k_const = 32'hfe2ce6e0;
      6'd58: k_const = 32'ha3014314;  6'd59: k_const = 32'h4e0811a1;
      6'd60: k_const = 32'hf7537e82;  6'd61: k_const = 32'hbd3af235;
      6'd62: k_const = 32'h2ad7d2bb;  default: k_const = 32'heb86d391;
    endcase
  end

  // Rotate via a doubled word so the shift amount never needs a (32 - s) term.
  assign m_word   = blk[{g_idx, 5'd0} +: 32];
  assign t_sum    = fn + wa + k_const + m_word;
  assign rot_wide = {t_sum, t_sum} << shamt;
  assign new_b    = wb + rot_wide[63:32];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      default: if (last_step) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      blk      <= '0;
      wa       <= '0;
      wb       <= '0;
      wc       <= '0;
      wd       <= '0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
      complete <= 1'b0;
      count    <= '0;
    end else begin
      en_q <= en;
      case (state)
        IDLE: begin
          if (start) begin
            blk   <= msg;
            wa    <= A;
            wb    <= B;
            wc    <= C;
            wd    <= D;
            count <= 8'd0;
          end
        end
        default: begin
          wa    <= wd;
          wb    <= new_b;
          wc    <= wb;
          wd    <= wc;
          count <= count + 8'd1;
          if (last_step) begin
            a        <= wd;
            b        <= new_b;
            c        <= wb;
            d        <= wc;
            complete <= ~complete;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_update.sv
// Self-checking bench for md5_update: known-answer digests, random blocks against
// a sine-table MD5 reference model, start-edge handling, reset abort and count trace.
module tb_md5_update;

  logic         clk;
  logic         reset;
  logic [511:0] msg;
  logic         en;
  logic [8:0]   input_len;
  logic [31:0]  A, B, C, D;
  logic [31:0]  a, b, c, d;
  logic         complete;
  logic [7:0]   count;

  int tests_run;
  int fail_count;

  int shift_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  md5_update dut (
    .clk(clk), .reset(reset), .msg(msg), .en(en), .input_len(input_len),
    .A(A), .B(B), .C(C), .D(D),
    .a(a), .b(b), .c(c), .d(d),
    .complete(complete), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straight from the MD5 definition, constants derived from sin().
  function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [31:0] ia,
                                           input logic [31:0] ib, input logic [31:0] ic,
                                           input logic [31:0] id);
    logic [31:0] va, vb, vc, vd, f, k, t, tmp, rot;
    int g, s;
    real x;
    va = ia; vb = ib; vc = ic; vd = id;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (vb & vc) | (~vb & vd); g = i; end
        1: begin f = (vb & vd) | (vc & ~vd); g = (5 * i + 1) % 16; end
        2: begin f = vb ^ vc ^ vd;           g = (3 * i + 5) % 16; end
        default: begin f = vc ^ (vb | ~vd);  g = (7 * i) % 16; end
      endcase
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      k = 32'(longint'($floor(x * 4294967296.0)));
      s = shift_tab[(i / 16) * 4 + (i % 4)];
      t = f + va + k + m[32 * g +: 32];
      rot = (t << s) | (t >> (32 - s));
      tmp = vd;
      vd = vc;
      vc = vb;
      vb = vb + rot;
      va = tmp;
    end
    return {va, vb, vc, vd};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  // Raises en for one edge (E0) and returns just after it with en low again.
  task automatic start_block();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Counts rising edges until complete toggles; -1 when the budget runs out.
  task automatic wait_complete(output int edges);
    logic prev;
    prev = complete;
    edges = 0;
    while (complete == prev && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (complete == prev) edges = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({a, b, c, d} !== 128'd0 || complete !== 1'b0 || count !== 8'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_state: abcd=%h complete=%b count=%0d, want 0/0/0",
               {a, b, c, d}, complete, count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_known(input string name, input logic [511:0] m,
                            input logic [127:0] digest);
    int edges;
    msg = m; A = IV_A; B = IV_B; C = IV_C; D = IV_D;
    start_block();
    wait_complete(edges);
    tests_run++;
    if (edges !== 64) begin
      fail_count++;
      $display("[TB] FAIL %s_latency: got %0d edges, want 64", name, edges);
    end
    tests_run++;
    if ({IV_A + a, IV_B + b, IV_C + c, IV_D + d} !== digest) begin
      fail_count++;
      $display("[TB] FAIL %s_digest: got %h, want %h", name,
               {IV_A + a, IV_B + b, IV_C + c, IV_D + d}, digest);
    end
  endtask

  task automatic test_random(input int n);
    int edges;
    logic [127:0] exp;
    for (int i = 0; i < n; i++) begin
      msg = rand_block();
      A = $urandom; B = $urandom; C = $urandom; D = $urandom;
      input_len = 9'($urandom_range(0, 64));
      exp = md5_ref(msg, A, B, C, D);
      start_block();
      wait_complete(edges);
      tests_run++;
      if (edges !== 64 || {a, b, c, d} !== exp) begin
        fail_count++;
        $display("[TB] FAIL random_%0d: edges=%0d abcd=%h, want 64 and %h",
                 i, edges, {a, b, c, d}, exp);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_hold_en();
    int toggles;
    logic prev;
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    toggles = 0;
    prev = complete;
    @(negedge clk);
    en = 1'b1;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (complete !== prev) toggles++;
      prev = complete;
    end
    tests_run++;
    if (toggles !== 1) begin
      fail_count++;
      $display("[TB] FAIL hold_en_toggles: got %0d, want 1", toggles);
    end
    tests_run++;
    if (count !== 8'd64) begin
      fail_count++;
      $display("[TB] FAIL hold_en_count: got %0d, want 64", count);
    end
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int edges, extra;
    logic prev;
    logic [127:0] exp;
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    exp = md5_ref(msg, A, B, C, D);
    start_block();
    repeat (30) @(posedge clk);
    #1;
    // Second edge plus scrambled inputs mid-block must both be ignored.
    en = 1'b1;
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_complete(edges);
    tests_run++;
    if (edges < 0 || edges + 31 !== 64) begin
      fail_count++;
      $display("[TB] FAIL retrigger_latency: got %0d edges, want 64", edges + 31);
    end
    tests_run++;
    if ({a, b, c, d} !== exp) begin
      fail_count++;
      $display("[TB] FAIL retrigger_result: got %h, want %h", {a, b, c, d}, exp);
    end
    prev = complete;
    extra = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (complete !== prev) extra++;
      prev = complete;
    end
    tests_run++;
    if (extra !== 0) begin
      fail_count++;
      $display("[TB] FAIL retrigger_extra_toggle: got %0d, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    logic [127:0] exp;
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    start_block();
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({a, b, c, d} !== 128'd0 || complete !== 1'b0 || count !== 8'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_mid_state: abcd=%h complete=%b count=%0d, want 0/0/0",
               {a, b, c, d}, complete, count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    tests_run++;
    if (complete !== 1'b0 || count !== 8'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_mid_aborted: complete=%b count=%0d, want 0/0",
               complete, count);
    end
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    exp = md5_ref(msg, A, B, C, D);
    start_block();
    wait_complete(edges);
    tests_run++;
    if (edges !== 64 || {a, b, c, d} !== exp || complete !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL reset_mid_restart: edges=%0d abcd=%h complete=%b, want 64 %h 1",
               edges, {a, b, c, d}, exp, complete);
    end
  endtask

  task automatic test_count_trace();
    int bad;
    bad = 0;
    msg = rand_block();
    A = $urandom; B = $urandom; C = $urandom; D = $urandom;
    repeat (2) @(negedge clk);
    start_block();
    tests_run++;
    if (count !== 8'd0) begin
      fail_count++;
      $display("[TB] FAIL count_start: got %0d, want 0", count);
    end
    for (int k = 1; k <= 74; k++) begin
      @(posedge clk);
      #1;
      if (count !== 8'((k > 64) ? 64 : k)) begin
        if (bad == 0)
          $display("[TB] FAIL count_trace: edge %0d got %0d, want %0d",
                   k, count, (k > 64) ? 64 : k);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) fail_count++;
  endtask

  initial begin
    logic [511:0] m;
    tests_run  = 0;
    fail_count = 0;
    en = 1'b0;
    msg = '0;
    input_len = '0;
    A = '0; B = '0; C = '0; D = '0;

    test_reset();

    m = '0;
    m[7:0] = 8'h80;
    input_len = 9'd0;
    test_known("empty", m, 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);

    m = '0;
    m[31:0] = 32'h80636261;
    m[511:448] = 64'd24;
    input_len = 9'd3;
    test_known("abc", m, 128'h98500190_b04fd23c_7d3f96d6_727fe128);

    test_random(4);
    test_hold_en();
    test_back_to_back();
    test_reset_mid();
    test_count_trace();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
